// File: rtl/spi_slave_burst_ctrl.sv
// Burst sequencer for the SPI slave: times the dummy phase of a read, then issues
// one bus word request per SPI word, wrapping inside a window of wrap_length words.
module spi_slave_burst_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic                  sclk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  is_read,
  input  logic [7:0]            dummy_cycles,
  input  logic [15:0]           wrap_length,
  input  logic                  word_done,
  input  logic                  cs_end,
  output logic                  req_valid,
  output logic                  req_we,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  busy,
  output logic                  dummy_active,
  output logic                  data_phase,
  output logic [15:0]           word_cnt
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(WORD_BYTES - 1));
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(WORD_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_DUMMY, S_DATA} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] base, base_n;
  logic [ADDR_WIDTH-1:0] cur, cur_n;
  logic [15:0]           wcnt, wcnt_n;
  logic [15:0]           wlen, wlen_n;
  logic [7:0]            dcnt, dcnt_n;
  logic                  rd, rd_n;
  logic                  req_valid_n, req_we_n;
  logic [ADDR_WIDTH-1:0] req_addr_n;

  logic [ADDR_WIDTH-1:0] cur_adv;
  logic [15:0]           wcnt_adv;

  function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] a);
    return a & ALIGN_MASK;
  endfunction

  function automatic logic wrap_hit(input logic [15:0] cnt, input logic [15:0] len);
    return (len != 16'd0) && ((cnt + 16'd1) == len);
  endfunction

  // Next word position inside the burst window
  always_comb begin
    if (wrap_hit(wcnt, wlen)) begin
      cur_adv  = base;
      wcnt_adv = 16'd0;
    end else begin
      cur_adv  = cur + ADDR_STEP;
      wcnt_adv = wcnt + 16'd1;
    end
  end

  always_comb begin
    state_n     = state;
    base_n      = base;
    cur_n       = cur;
    wcnt_n      = wcnt;
    wlen_n      = wlen;
    dcnt_n      = dcnt;
    rd_n        = rd;
    req_valid_n = 1'b0;
    req_we_n    = req_we;
    req_addr_n  = req_addr;

    if (cs_end) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            base_n = align_addr(start_addr);
            cur_n  = align_addr(start_addr);
            wcnt_n = 16'd0;
            wlen_n = wrap_length;
            dcnt_n = dummy_cycles - 8'd1;
            rd_n   = is_read;
            if (is_read) begin
              // Read prefetch of the first word overlaps the dummy phase
              req_valid_n = 1'b1;
              req_we_n    = 1'b0;
              req_addr_n  = align_addr(start_addr);
              state_n     = (dummy_cycles != 8'd0) ? S_DUMMY : S_DATA;
            end else begin
              state_n = S_DATA;
            end
          end
        end
        S_DUMMY: begin
          dcnt_n = dcnt - 8'd1;
          if (dcnt == 8'd0) state_n = S_DATA;
        end
        S_DATA: begin
          if (word_done) begin
            cur_n       = cur_adv;
            wcnt_n      = wcnt_adv;
            req_valid_n = 1'b1;
            req_we_n    = ~rd;
            // Writes store the word just received; reads fetch one word ahead
            req_addr_n  = rd ? cur_adv : cur;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state     <= S_IDLE;
      base      <= '0;
      cur       <= '0;
      wcnt      <= 16'd0;
      wlen      <= 16'd0;
      dcnt      <= 8'd0;
      rd        <= 1'b0;
      req_valid <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
    end else begin
      state     <= state_n;
      base      <= base_n;
      cur       <= cur_n;
      wcnt      <= wcnt_n;
      wlen      <= wlen_n;
      dcnt      <= dcnt_n;
      rd        <= rd_n;
      req_valid <= req_valid_n;
      req_we    <= req_we_n;
      req_addr  <= req_addr_n;
    end
  end

  assign busy         = (state != S_IDLE);
  assign dummy_active = (state == S_DUMMY);
  assign data_phase   = (state == S_DATA);
  assign word_cnt     = wcnt;

endmodule

// File: tb/tb_spi_slave_burst_ctrl.sv
// Randomized and directed bench for spi_slave_burst_ctrl against a word-index
// reference model of the burst address sequence.
module tb_spi_slave_burst_ctrl;

  localparam int WB = 4;

  logic        sclk;
  logic        rst;
  logic        start;
  logic [31:0] start_addr;
  logic        is_read;
  logic [7:0]  dummy_cycles;
  logic [15:0] wrap_length;
  logic        word_done;
  logic        cs_end;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic        busy;
  logic        dummy_active;
  logic        data_phase;
  logic [15:0] word_cnt;

  spi_slave_burst_ctrl #(.ADDR_WIDTH(32), .WORD_BYTES(WB)) dut (
    .sclk(sclk), .rst(rst), .start(start), .start_addr(start_addr), .is_read(is_read),
    .dummy_cycles(dummy_cycles), .wrap_length(wrap_length), .word_done(word_done),
    .cs_end(cs_end), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .busy(busy), .dummy_active(dummy_active), .data_phase(data_phase), .word_cnt(word_cnt)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: mode 0=idle 1=dummy 2=data; m_n counts words since start
  int          m_mode = 0;
  logic [31:0] m_base = '0;
  int          m_n    = 0;
  logic [15:0] m_wlen = '0;
  int          m_drem = 0;
  logic        m_rd   = 1'b0;
  logic        m_rv   = 1'b0;
  logic        m_we   = 1'b0;
  logic [31:0] m_addr = '0;
  logic [15:0] m_cnt  = '0;
  logic [52:0] exp_vec;

  function automatic logic [31:0] addr_of(input int n);
    int idx;
    idx = (m_wlen == 16'd0) ? n : (n % int'(m_wlen));
    return m_base + 32'(idx * WB);
  endfunction

  function automatic logic [15:0] cnt_of(input int n);
    return (m_wlen == 16'd0) ? 16'(n) : 16'(n % int'(m_wlen));
  endfunction

  function automatic logic [52:0] act_vec();
    return {req_valid, req_valid & req_we, req_valid ? req_addr : 32'h0,
            busy, dummy_active, data_phase, word_cnt};
  endfunction

  task automatic step(input logic r, input logic st, input logic [31:0] a, input logic rdb,
                      input logic [7:0] d, input logic [15:0] w, input logic wd, input logic cs);
    rst = r; start = st; start_addr = a; is_read = rdb;
    dummy_cycles = d; wrap_length = w; word_done = wd; cs_end = cs;
    m_rv = 1'b0;
    if (r) begin
      m_mode = 0; m_n = 0; m_cnt = '0; m_we = 1'b0; m_addr = '0;
    end else if (cs) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (st) begin
          m_base = a & ~32'(WB - 1);
          m_n = 0; m_cnt = '0; m_wlen = w; m_rd = rdb; m_drem = int'(d);
          if (rdb) begin m_rv = 1'b1; m_we = 1'b0; m_addr = m_base; end
          m_mode = (rdb && d != 8'd0) ? 1 : 2;
        end
        1: begin
          m_drem--;
          if (m_drem == 0) m_mode = 2;
        end
        default: if (wd) begin
          if (!m_rd) begin
            m_rv = 1'b1; m_we = 1'b1; m_addr = addr_of(m_n); m_n++;
          end else begin
            m_n++; m_rv = 1'b1; m_we = 1'b0; m_addr = addr_of(m_n);
          end
          m_cnt = cnt_of(m_n);
        end
      endcase
    end
    exp_vec = {m_rv, m_rv & m_we, m_rv ? m_addr : 32'h0,
               m_mode != 0, m_mode == 1, m_mode == 2, m_cnt};
    @(posedge sclk);
    @(negedge sclk);
    cyc++;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 32'h0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0);
      total++;
      if (act_vec() !== exp_vec || req_we !== 1'b0 || req_addr !== 32'h0) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%h we=%b addr=%h exp=%h", cyc, act_vec(), req_we, req_addr, exp_vec);
      end
    end
  endtask

  task automatic test_read_linear();
    int          ndum;
    logic [31:0] got [$];
    logic [31:0] ea [3];
    ea = '{32'h1004, 32'h1008, 32'h100C};
    ndum = 0;
    step(1'b0, 1'b1, 32'h1003, 1'b1, 8'd3, 16'd0, 1'b0, 1'b0);
    total++;
    if (act_vec() !== exp_vec || req_addr !== 32'h1000) begin
      bad++;
      $display("FAIL read_prefetch got=%h exp=%h", act_vec(), exp_vec);
    end
    if (dummy_active) ndum++;
    for (int i = 0; i < 3; i++) begin
      idle_step();
      if (dummy_active) ndum++;
      total++;
      if (act_vec() !== exp_vec) begin
        bad++;
        $display("FAIL read_dummy cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
      end
    end
    total++;
    if (ndum !== 3) begin
      bad++;
      $display("FAIL dummy_len got=%0d exp=3", ndum);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
      if (req_valid) got.push_back(req_addr);
      total++;
      if (act_vec() !== exp_vec) begin
        bad++;
        $display("FAIL read_word cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
      end
    end
    total++;
    if (got.size() != 3 || got[0] !== ea[0] || got[1] !== ea[1] || got[2] !== ea[2]) begin
      bad++;
      $display("FAIL read_addrs got_n=%0d first=%h exp=%h", got.size(), (got.size() > 0) ? got[0] : 32'h0, ea[0]);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b1);
  endtask

  task automatic test_write_wrap();
    logic [31:0] ea [6];
    logic [15:0] ec [6];
    ea = '{32'h2000, 32'h2004, 32'h2008, 32'h200C, 32'h2000, 32'h2004};
    ec = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd2};
    step(1'b0, 1'b1, 32'h2000, 1'b0, 8'd5, 16'd4, 1'b0, 1'b0);
    total++;
    if (act_vec() !== exp_vec || req_valid !== 1'b0 || data_phase !== 1'b1) begin
      bad++;
      $display("FAIL write_start got=%h exp=%h", act_vec(), exp_vec);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
      total++;
      if (act_vec() !== exp_vec || req_we !== 1'b1 || req_addr !== ea[i] || word_cnt !== ec[i]) begin
        bad++;
        $display("FAIL write_wrap i=%0d got=%h addr=%h cnt=%0d exp_addr=%h exp_cnt=%0d",
                 i, act_vec(), req_addr, word_cnt, ea[i], ec[i]);
      end
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b1);
  endtask

  task automatic test_dummy_zero();
    step(1'b0, 1'b1, 32'h0, 1'b1, 8'd0, 16'd0, 1'b0, 1'b0);
    total++;
    if (act_vec() !== exp_vec || dummy_active !== 1'b0 || data_phase !== 1'b1 || req_valid !== 1'b1) begin
      bad++;
      $display("FAIL dummy_zero got=%h exp=%h", act_vec(), exp_vec);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 8'd0, 16'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
    total++;
    if (act_vec() !== exp_vec || req_addr !== 32'h0 || req_valid !== 1'b1) begin
      bad++;
      $display("FAIL addr_rollover got=%h addr=%h exp=%h", act_vec(), req_addr, exp_vec);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    step(1'b0, 1'b1, 32'h3000, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b1);
    total++;
    if (act_vec() !== exp_vec || req_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL cs_end_word got=%h exp=%h", act_vec(), exp_vec);
    end
    step(1'b0, 1'b1, 32'h4000, 1'b0, 8'd0, 16'd0, 1'b0, 1'b1);
    total++;
    if (act_vec() !== exp_vec || busy !== 1'b0) begin
      bad++;
      $display("FAIL start_cs_idle got=%h exp=%h", act_vec(), exp_vec);
    end
    step(1'b0, 1'b1, 32'h5000, 1'b0, 8'd0, 16'd2, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h6000, 1'b1, 8'd4, 16'd0, 1'b0, 1'b0);
    total++;
    if (act_vec() !== exp_vec || req_valid !== 1'b0 || data_phase !== 1'b1) begin
      bad++;
      $display("FAIL start_in_data got=%h exp=%h", act_vec(), exp_vec);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
    total++;
    if (act_vec() !== exp_vec || req_addr !== 32'h5000 || req_we !== 1'b1) begin
      bad++;
      $display("FAIL after_ignored_start got=%h exp=%h", act_vec(), exp_vec);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int ndum;
    step(1'b0, 1'b1, 32'h7000, 1'b1, 8'd8, 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 8'd1, 16'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 8'd1, 16'd0, 1'b1, 1'b0);
    total++;
    if (act_vec() !== exp_vec || {req_valid, req_we, req_addr, busy, dummy_active, data_phase, word_cnt} !== 53'h0) begin
      bad++;
      $display("FAIL reset_mid got=%h exp=%h", act_vec(), exp_vec);
    end
    ndum = 0;
    step(1'b0, 1'b1, 32'h7100, 1'b1, 8'd4, 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (dummy_active) ndum++;
      step(1'b0, 1'b0, 32'h0, 1'b0, 8'd1, 16'd0, 1'b0, 1'b0);
      total++;
      if (act_vec() !== exp_vec) begin
        bad++;
        $display("FAIL dummy_regchange cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
      end
    end
    total++;
    if (ndum !== 4) begin
      bad++;
      $display("FAIL dummy_len_fixed got=%0d exp=4", ndum);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [15:0] wraps [5];
    wraps = '{16'd0, 16'd1, 16'd3, 16'd4, 16'd7};
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 5) == 0),
           $urandom,
           $urandom_range(0, 1) == 1,
           8'($urandom_range(0, 5)),
           wraps[$urandom_range(0, 4)],
           $urandom_range(0, 1) == 1,
           ($urandom_range(0, 39) == 0));
      total++;
      if (act_vec() !== exp_vec) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, act_vec(), exp_vec);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0; is_read = 1'b0;
    dummy_cycles = '0; wrap_length = '0; word_done = 1'b0; cs_end = 1'b0;
    test_reset();
    test_read_linear();
    test_write_wrap();
    test_dummy_zero();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
